clock_set_ctrl: RTL and testbench

Mode/sequencing controller for the clock datapath (second, minute and hour counters).
- Derives the 1 Hz tick from the system clock.
- In RUN mode, gates the tick to the seconds counter.
- Provides a two-step time-set mode driven by two debounced buttons, with auto-repeat, idle timeout and a display blink enable.
- Sits between the board buttons/oscillator and the counter chain; it drives the counters' increment enables and the seconds clear.

---
 rtl/clock_set_ctrl.sv | 154 +++++++++++++++
 tb/tb_clock_set_ctrl.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/clock_set_ctrl.sv
// clock_set_ctrl
//   Mode and sequencing controller for the seconds/minutes/hours counter chain.
//   It divides clk down to a 1 Hz tick and passes that tick to the seconds
//   counter while in RUN. It also provides a two-step time-set mode (hours,
//   then minutes) driven by two debounced buttons. Set mode has auto-repeat,
//   an idle timeout and a blink enable for the field being edited.
//
// Ports
//   clk       in   system clock, rising edge
//   reset     in   asynchronous, active-low reset
//   btn_mode  in   debounced mode button level (active high)
//   btn_inc   in   debounced increment button level (active high)
//   sec_tick  out  1-cycle, 1 Hz advance pulse for the seconds counter (RUN only)
//   sec_clr   out  1-cycle clear for the seconds counter on entry to set mode
//   min_inc   out  1-cycle minute increment (SET_MIN)
//   hour_inc  out  1-cycle hour increment (SET_HOUR)
//   mode      out  0 = RUN, 1 = SET_HOUR, 2 = SET_MIN
//   blink     out  display enable for the field being edited
//
// State table
//   state       | meaning
//   ST_RUN      | time running, sec_tick follows the 1 Hz tick
//   ST_SET_HOUR | time frozen, inc button advances hours
//   ST_SET_MIN  | time frozen, inc button advances minutes

module clock_set_ctrl #(
    parameter int TICK_DIV      = 50000000,
    parameter int HOLD_CYCLES   = 25000000,
    parameter int REPEAT_CYCLES = 10000000,
    parameter int TIMEOUT_SEC   = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_mode,
    input  logic       btn_inc,
    output logic       sec_tick,
    output logic       sec_clr,
    output logic       min_inc,
    output logic       hour_inc,
    output logic [1:0] mode,
    output logic       blink
);

    localparam int PW = $clog2(TICK_DIV);
    localparam int HW = $clog2(HOLD_CYCLES + 1);
    localparam int RW = $clog2(REPEAT_CYCLES + 1);
    localparam int IW = $clog2(TIMEOUT_SEC + 1);

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_SET_HOUR = 2'd1,
        ST_SET_MIN  = 2'd2
    } state_t;

    state_t          state, state_nxt;
    logic [PW-1:0]   presc, presc_nxt;
    logic [HW-1:0]   hold_cnt, hold_nxt;
    logic [RW-1:0]   rep_cnt, rep_nxt;
    logic [IW-1:0]   idle_cnt, idle_nxt;
    logic            mode_prev, inc_prev;

    logic            mode_edge, inc_edge, tick_1hz, in_set, hold_done;
    logic            rep_fire, inc_pulse, idle_clr, timeout, changing;
    logic            sec_tick_nxt, sec_clr_nxt, min_inc_nxt, hour_inc_nxt, blink_nxt;

    assign mode = state;

    always_comb begin
        mode_edge = btn_mode & ~mode_prev;
        inc_edge  = btn_inc & ~inc_prev;
        tick_1hz  = (presc == PW'(TICK_DIV - 1));
        in_set    = (state != ST_RUN);
        hold_done = (hold_cnt == HW'(HOLD_CYCLES));

        // The first repeat comes when the held count reaches HOLD_CYCLES.
        // After that, hold_cnt stays saturated and rep_cnt paces the later
        // repeats, so neither counter wraps.
        rep_fire  = in_set & btn_inc &
                    (hold_done ? (rep_cnt == '0) : (hold_cnt == HW'(HOLD_CYCLES - 1)));
        inc_pulse = in_set & ~mode_edge & (inc_edge | rep_fire);
        idle_clr  = mode_edge | inc_edge | rep_fire;
        timeout   = in_set & tick_1hz & ~idle_clr & (idle_cnt == IW'(TIMEOUT_SEC - 1));

        state_nxt = state;
        case (state)
            ST_RUN:      if (mode_edge) state_nxt = ST_SET_HOUR;
            ST_SET_HOUR: if (mode_edge) state_nxt = ST_SET_MIN;
                         else if (timeout) state_nxt = ST_RUN;
            ST_SET_MIN:  if (mode_edge || timeout) state_nxt = ST_RUN;
            default:     state_nxt = ST_RUN;
        endcase
        changing = (state_nxt != state);

        presc_nxt = (changing || tick_1hz) ? '0 : presc + PW'(1);

        hold_nxt = hold_cnt;
        rep_nxt  = rep_cnt;
        if (!in_set || !btn_inc || changing) begin
            hold_nxt = '0;
            rep_nxt  = '0;
        end else if (!hold_done) begin
            hold_nxt = hold_cnt + HW'(1);
            if (rep_fire) rep_nxt = RW'(REPEAT_CYCLES - 1);
        end else if (rep_cnt == '0) begin
            rep_nxt = RW'(REPEAT_CYCLES - 1);
        end else begin
            rep_nxt = rep_cnt - RW'(1);
        end

        idle_nxt = idle_cnt;
        if (changing || idle_clr || !in_set) idle_nxt = '0;
        else if (tick_1hz)                   idle_nxt = idle_cnt + IW'(1);

        // A tick that lands on a state change is dropped, so sec_tick
        // never shows up outside RUN.
        sec_tick_nxt = (state == ST_RUN) & (state_nxt == ST_RUN) & tick_1hz;
        sec_clr_nxt  = (state == ST_RUN) & mode_edge;
        hour_inc_nxt = (state == ST_SET_HOUR) & inc_pulse;
        min_inc_nxt  = (state == ST_SET_MIN) & inc_pulse;
        blink_nxt    = (state_nxt == ST_RUN) | (presc_nxt < PW'(TICK_DIV / 2));
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= ST_RUN;
            presc     <= '0;
            hold_cnt  <= '0;
            rep_cnt   <= '0;
            idle_cnt  <= '0;
            // Buttons held through reset release must not look like an edge.
            mode_prev <= 1'b1;
            inc_prev  <= 1'b1;
            sec_tick  <= 1'b0;
            sec_clr   <= 1'b0;
            min_inc   <= 1'b0;
            hour_inc  <= 1'b0;
            blink     <= 1'b1;
        end else begin
            state     <= state_nxt;
            presc     <= presc_nxt;
            hold_cnt  <= hold_nxt;
            rep_cnt   <= rep_nxt;
            idle_cnt  <= idle_nxt;
            mode_prev <= btn_mode;
            inc_prev  <= btn_inc;
            sec_tick  <= sec_tick_nxt;
            sec_clr   <= sec_clr_nxt;
            min_inc   <= min_inc_nxt;
            hour_inc  <= hour_inc_nxt;
            blink     <= blink_nxt;
        end
    end

endmodule

// File: tb/tb_clock_set_ctrl.sv
module tb_clock_set_ctrl;

    localparam int TD = 10;
    localparam int HC = 8;
    localparam int RC = 4;
    localparam int TO = 3;

    logic       clk, reset, btn_mode, btn_inc;
    logic       sec_tick, sec_clr, min_inc, hour_inc, blink;
    logic [1:0] mode;

    clock_set_ctrl #(
        .TICK_DIV(TD), .HOLD_CYCLES(HC), .REPEAT_CYCLES(RC), .TIMEOUT_SEC(TO)
    ) dut (
        .clk(clk), .reset(reset), .btn_mode(btn_mode), .btn_inc(btn_inc),
        .sec_tick(sec_tick), .sec_clr(sec_clr), .min_inc(min_inc),
        .hour_inc(hour_inc), .mode(mode), .blink(blink)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state. Time is tracked as cycles since the last mode
    // change, hold as the number of consecutive held cycles, and idle as
    // 1 Hz ticks seen since the last activity.
    int   m_mode, m_since, m_held, m_idle;
    bit   m_pm, m_pi;
    logic e_tick, e_clr, e_min, e_hour, e_blink;

    int   cnt, pos_mask, first_tick, run;
    bit   bi_lvl, bm_r;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_mode = 0; m_since = 0; m_held = 0; m_idle = 0;
        m_pm = 1'b1; m_pi = 1'b1;
        e_tick = 0; e_clr = 0; e_min = 0; e_hour = 0; e_blink = 1;
    endtask

    task automatic model_step(input bit bm, input bit bi);
        bit tick, medge, iedge, rep, clr, changed, pulse;
        int held_now, idle_after, new_mode;
        tick     = ((m_since % TD) == TD - 1);
        medge    = bm && !m_pm;
        iedge    = bi && !m_pi;
        held_now = (m_mode != 0 && bi) ? m_held + 1 : 0;
        rep      = (m_mode != 0) && (held_now >= HC) && (((held_now - HC) % RC) == 0);
        clr      = medge || iedge || rep;
        idle_after = clr ? 0 : ((m_mode != 0 && tick) ? m_idle + 1 : m_idle);
        new_mode = m_mode;
        if (medge)                             new_mode = (m_mode + 1) % 3;
        else if (m_mode != 0 && idle_after == TO) new_mode = 0;
        changed  = (new_mode != m_mode);
        pulse    = (m_mode != 0) && !medge && (iedge || rep);
        e_tick   = (m_mode == 0) && !changed && tick;
        e_clr    = (m_mode == 0) && medge;
        e_hour   = pulse && (m_mode == 1);
        e_min    = pulse && (m_mode == 2);
        m_since  = changed ? 0 : m_since + 1;
        m_held   = changed ? 0 : held_now;
        m_idle   = changed ? 0 : idle_after;
        m_mode   = new_mode;
        m_pm     = bm;
        m_pi     = bi;
        e_blink  = (m_mode == 0) || ((m_since % TD) < TD / 2);
    endtask

    task automatic check_all();
        chk("mode",     {30'd0, mode},     m_mode);
        chk("blink",    {31'd0, blink},    {31'd0, e_blink});
        chk("sec_tick", {31'd0, sec_tick}, {31'd0, e_tick});
        chk("sec_clr",  {31'd0, sec_clr},  {31'd0, e_clr});
        chk("min_inc",  {31'd0, min_inc},  {31'd0, e_min});
        chk("hour_inc", {31'd0, hour_inc}, {31'd0, e_hour});
    endtask

    // Called just after a rising edge: drive, clock, check 1 ns later.
    task automatic cyc(input bit bm, input bit bi);
        btn_mode = bm;
        btn_inc  = bi;
        @(posedge clk);
        model_step(bm, bi);
        #1;
        check_all();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b0; btn_mode = 1'b0; btn_inc = 1'b0;
        model_reset();
        @(posedge clk); #1;
        check_all();
        reset = 1'b1;

        // Free-running ticks after reset release.
        cnt = 0; first_tick = -1;
        for (int j = 1; j <= 35; j++) begin
            cyc(0, 0);
            if (sec_tick) begin
                cnt++;
                if (first_tick < 0) first_tick = j;
            end
        end
        chk("run_tick_count", cnt, 3);
        chk("run_first_tick", first_tick, 10);

        // Enter SET_HOUR, observe blink.
        cyc(1, 0);
        chk("enter_sethour_clr", {31'd0, sec_clr}, 1);
        for (int j = 0; j < 12; j++) cyc(0, 0);

        // Three separate hour presses.
        cnt = 0;
        for (int p = 0; p < 3; p++) begin
            cyc(0, 1); cnt += hour_inc;
            cyc(0, 1); cnt += hour_inc;
            cyc(0, 0); cnt += hour_inc;
            cyc(0, 0); cnt += hour_inc;
        end
        chk("hour_press_count", cnt, 3);
        cyc(1, 0);
        chk("enter_setmin", {30'd0, mode}, 2);
        cnt = 0;
        cyc(0, 1); cnt += min_inc;
        cyc(0, 1); cnt += min_inc;
        cyc(0, 0); cnt += min_inc;
        chk("min_press_count", cnt, 1);

        // Auto-repeat while held.
        cnt = 0; pos_mask = 0;
        for (int j = 1; j <= 20; j++) begin
            cyc(0, 1);
            if (min_inc) begin cnt++; pos_mask |= (1 << j); end
        end
        for (int j = 0; j < 5; j++) begin
            cyc(0, 0);
            cnt += min_inc;
        end
        chk("repeat_count", cnt, 5);
        chk("repeat_positions", pos_mask, (1 << 1) | (1 << 8) | (1 << 12) | (1 << 16) | (1 << 20));

        // Idle timeout out of SET_HOUR.
        cyc(1, 0);
        cyc(0, 0);
        cyc(1, 0);
        cnt = 0; first_tick = -1;
        for (int j = 1; j <= 40; j++) begin
            cyc(0, 0);
            cnt += sec_clr;
            if (j == 29) chk("timeout_not_yet", {30'd0, mode}, 1);
            if (j == 30) chk("timeout_run", {30'd0, mode}, 0);
            if (sec_tick && first_tick < 0) first_tick = j;
        end
        chk("timeout_no_clr", cnt, 0);
        chk("timeout_first_tick", first_tick, 40);

        // Mode and inc edges together.
        cyc(1, 0);
        cyc(0, 0);
        cyc(1, 1);
        chk("simul_mode", {30'd0, mode}, 2);
        chk("simul_no_hour", {31'd0, hour_inc}, 0);
        for (int j = 0; j < 5; j++) cyc(0, 1);

        // Asynchronous reset mid-cycle while inc is held.
        #2;
        reset = 1'b0;
        #1;
        model_reset();
        check_all();
        @(posedge clk); #1;
        check_all();
        reset = 1'b1;
        cnt = 0;
        for (int j = 0; j < 15; j++) begin
            cyc(0, 1);
            cnt += min_inc + hour_inc;
        end
        chk("post_reset_no_inc", cnt, 0);
        chk("post_reset_mode", {30'd0, mode}, 0);

        // Randomized traffic against the model.
        run = 0; bi_lvl = 1'b0;
        for (int j = 0; j < 800; j++) begin
            if (run == 0) begin
                bi_lvl = ($urandom_range(0, 1) == 1);
                run = $urandom_range(1, 25);
            end
            run--;
            bm_r = ($urandom_range(0, 19) == 0);
            cyc(bm_r, bi_lvl);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
